// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front end for a single-port synchronous data RAM.
// Each access runs a fixed sequence: IDLE -> ISSUE -> (WAIT) -> RESP.
// Bad requests skip the RAM and go straight to RESP.
module lsu_mem_ctrl #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [1:0]  SZ_B = 2'b00;
    localparam logic [1:0]  SZ_H = 2'b01;
    localparam logic [1:0]  SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        req_bad;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [15:0] ld_shift;
    logic [31:0] ld_data;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Classify the incoming request: illegal size, misaligned, or beyond the RAM
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_B:    req_bad = 1'b0;
            SZ_H:    req_bad = req_addr[0];
            SZ_W:    req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
        if (req_addr >= MEM_LIMIT) req_bad = 1'b1;
    end

    // Replicate store data across lanes; byte enables select the target lanes
    always_comb begin
        st_wdata = req_wdata;
        st_be    = 4'b1111;
        case (req_size)
            SZ_B: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_be    = 4'b0001 << req_addr[1:0];
            end
            SZ_H: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_be    = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_wdata = req_wdata;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Right-align the addressed lane of the RAM word and extend it
    always_comb begin
        ld_shift = 16'(mem_rdata >> {off_q, 3'b000});
        case (size_q)
            SZ_B:    ld_data = uns_q ? {24'h0, ld_shift[7:0]}
                                     : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = uns_q ? {16'h0, ld_shift}
                                     : {{16{ld_shift[15]}}, ld_shift};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic; mem_we/mem_be/rsp_valid default low
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_we_d    = req_we;
                        mem_be_d    = req_we ? st_be : 4'b0000;
                        mem_wdata_d = req_we ? st_wdata : 32'h0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_data;
                rsp_err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and all registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a byte-enabled synchronous RAM model.
module tb_lsu_mem_ctrl;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one cycle after the address is sampled
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= ram[mem_addr[9:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } rsp_exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } wr_exp_t;
    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got an unexpected or missing event", nm);
    endtask

    // Monitor: every response and every RAM write must match the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) flag("unexpected_rsp_valid");
            else begin
                chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, rsp_q[0].err});
                chk("rsp_latency", 32'(cyc - rsp_q[0].acc + 1), 32'(rsp_q[0].lat));
                void'(rsp_q.pop_front());
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) flag("unexpected_mem_we");
            else begin
                chk("mem_addr", mem_addr, wr_q[0].addr);
                chk("mem_be", {28'h0, mem_be}, {28'h0, wr_q[0].be});
                chk("mem_wdata", mem_wdata, wr_q[0].wdata);
                void'(wr_q.pop_front());
            end
        end
    end

    // Issue one access, queue its expectations, then wait for the scoreboard to drain
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input logic ewr, input logic [31:0] eaddr,
                         input logic [3:0] ebe, input logic [31:0] ewd);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin flag("req_ready_timeout"); return; end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        rsp_q.push_back('{erd, eerr, elat, cyc});
        if (ewr) wr_q.push_back('{eaddr, ebe, ewd});
        // Scramble the request fields while busy; they must be ignored
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
        req_addr = a ^ 32'h0000_0005; req_wdata = ~wd;
        n = 0;
        while (rsp_q.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
        if (rsp_q.size() != 0) begin flag("rsp_timeout"); rsp_q.delete(); end
        if (wr_q.size() != 0) begin flag("missing_mem_we"); wr_q.delete(); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
        chk("reset_mem_be", {28'h0, mem_be}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        //    we    sz     uns   addr          wdata          exp_rdata      err  lat  wr    waddr         be       wdata
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0010, 4'b1000, 32'hA5A5_A5A5);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFA5, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00A5, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hA5AD_BEEF, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8001_7FFF, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0010, 4'b1111, 32'h8001_7FFF);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_8001, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_7FFF, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_007F, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h1111_1111, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0014, 4'b1111, 32'h1111_1111);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h1234_BEEF, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0014, 4'b1100, 32'hBEEF_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,         32'hBEEF_1111, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_03FF, 32'h0000_005A, 32'h0,         1'b0, 2, 1'b1, 32'h0000_03FC, 4'b1000, 32'h5A5A_5A5A);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,         32'h0000_005A, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        // Error cases: no RAM access, rdata forced to zero, one-cycle latency
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0BAD_0BAD, 32'h0,         1'b1, 1, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'h0000_00EE, 32'h0,         1'b1, 1, 1'b0, 32'h0, 4'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rsp_rdata_hold", rsp_rdata, 32'hCAFE_F00D);

        // Reset in the middle of a store's ISSUE cycle
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0, 2, 1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0020; req_wdata = 32'h5566_7788; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_mem_we_in_issue", {31'h0, mem_we}, 32'h1);
        rst = 1'b1; #1;
        chk("abort_mem_we_dropped", {31'h0, mem_we}, 32'h0);
        chk("abort_mem_be", {28'h0, mem_be}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready_after_release", {31'h0, req_ready}, 32'h1);
        chk("abort_ram_word_20", ram[8], 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0, 3, 1'b0, 32'h0, 4'b0, 32'h0);

        repeat (3) @(negedge clk);
        if (rsp_q.size() != 0) flag("leftover_rsp_expect");
        if (wr_q.size() != 0) flag("leftover_wr_expect");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, giving the addressable data-memory size in bytes (power of two).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the pipeline presents an access.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts an access this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit: zero-extend load data (LBU/LHU).
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: misaligned, illegal-size or out-of-range access.
REQ-014 The block SHALL have ports mem_addr (output, 32), mem_wdata (output, 32), mem_we (output, 1) and mem_be (output, 4): drive the synchronous RAM.
REQ-015 The block SHALL have port mem_rdata, input, 32 bits: RAM read data, valid one cycle after the address is sampled.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; an accept is req_valid && req_ready at a rising edge, and it latches all req_* fields.
REQ-018 An accepted request SHALL be flagged as an error if:
- req_size = 11; or
- half with addr[0] = 1; or
- word with addr[1:0] != 0; or
- addr >= MEM_BYTES.
REQ-019 An error request SHALL go IDLE -> RESP directly, with no memory access; mem_we SHALL remain 0.
REQ-020 A legal request SHALL go IDLE -> ISSUE; mem_addr, mem_wdata, mem_be and mem_we SHALL be driven from registers during ISSUE.
REQ-021 mem_we SHALL be 1 only in ISSUE of a store, for exactly one cycle.
REQ-022 Store lane steering SHALL be:
- byte: mem_wdata = four copies of wdata[7:0], mem_be = 0001 << addr[1:0];
- half: mem_wdata = two copies of wdata[15:0], mem_be = 0011 << addr[1:0];
- word: mem_wdata = wdata, mem_be = 1111.
REQ-023 For loads, mem_be SHALL be 0000 and mem_we SHALL be 0.
REQ-024 A store SHALL go ISSUE -> RESP; a load SHALL go ISSUE -> WAIT -> RESP.
REQ-025 In WAIT, load data SHALL be extracted and registered into rsp_rdata:
- byte: mem_rdata >> 8*addr[1:0], low 8 bits;
- half: mem_rdata >> 8*addr[1:0], low 16 bits;
- both: sign-extended unless req_unsigned is set, in which case zero-extended.
REQ-026 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-027 Latency from accept edge to rsp_valid high SHALL be: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-028 The next request SHALL be accepted no earlier than the cycle after RESP.
REQ-029 rsp_rdata and rsp_err SHALL hold their values until the next response is produced.
REQ-030 req_* changes while not in IDLE SHALL have no effect.
REQ-031 mem_addr SHALL be req_addr with bits [1:0] cleared.

Reset
REQ-032 While rst = 1, the block SHALL asynchronously force:
- state IDLE;
- mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-033 req_ready SHALL be 1 one cycle after rst deasserts.
REQ-034 Reset during ISSUE, WAIT or RESP SHALL abort the access with no rsp_valid pulse; a store aborted in ISSUE SHALL have mem_we dropped immediately.

Verification
REQ-035 Store word 0xDEADBEEF @0x10 -> mem_we = 1 for one cycle, mem_be = 1111, mem_addr = 0x10; rsp_valid 2 cycles after accept, rsp_err = 0.
REQ-036 Store byte 0x000000A5 @0x13, then load byte signed @0x13 -> store has mem_be = 1000, mem_wdata = 0xA5A5A5A5; load returns rsp_rdata = 0xFFFFFFA5 3 cycles after accept.
REQ-037 Load half unsigned @0x12 with RAM word 0x80017FFF -> rsp_rdata = 0x00008001; the same access signed -> 0xFFFF8001.
REQ-038 Misaligned cases:
- load word @0x102 -> rsp_err = 1, rsp_rdata = 0, rsp_valid 1 cycle after accept, no mem_we;
- req_size = 11 @0x0 -> identical behaviour.
REQ-039 Address 0x400 with MEM_BYTES = 1024 -> rsp_err = 1, no memory write; RAM contents unchanged.
REQ-040 Assert rst during ISSUE of a store @0x20 -> mem_we falls the same cycle, no rsp_valid, req_ready = 1 after release, word 0x20 unchanged.
